// File: rtl/ham_15_11_pkg.sv
// Shared definitions for the Hamming (15,11) encoder/serializer and its decoder.
// Index i of a codeword is Hamming position i+1. Parity bits occupy the
// power-of-two positions (indices 0,1,3,7) and data fills the rest in order.
package ham_15_11_pkg;

  localparam int CW_W     = 15;
  localparam int DATA_W   = 11;
  localparam int LAST_BIT = 14;

  // Codeword index of data bit d[i]
  localparam int DATA_POS [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};
  // Codeword index of parity bit p[j]; p[j] covers positions with bit j set
  localparam int PAR_POS [4] = '{0, 1, 3, 7};

  typedef enum logic {IDLE, SHIFT} state_t;

endpackage

// File: rtl/ham_15_11_encoder.sv
// Combinational Hamming (15,11) encoder, the inverse of the decoder's data map.
// Ports:
//   data : 11-bit data word
//   cw   : 15-bit codeword, cw[i] is Hamming position i+1
module ham_15_11_encoder
  import ham_15_11_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   cw
);

  always_comb begin
    cw = '0;
    for (int i = 0; i < DATA_W; i++) cw[DATA_POS[i]] = data[i];
    // Parity positions are powers of two, so each parity bit belongs only to
    // its own group; the others are still zero / excluded when it is formed.
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < CW_W; i++) begin
        if ((i != PAR_POS[j]) && ((((i + 1) >> j) & 1) != 0))
          cw[PAR_POS[j]] = cw[PAR_POS[j]] ^ cw[i];
      end
    end
  end

endmodule

// File: rtl/ham_15_11_encoder_ser.sv
// Hamming (15,11) encoder with optional single-bit error injection and a
// valid/ready bit-serial output carrying start/end-of-frame markers.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   d_in/d_valid/d_ready: 11-bit word input handshake
//   err_inj_en/pos      : flip cw[pos] of the accepted word (pos 15 = none)
//   cw_out              : codeword being transmitted, error applied
//   ser_out/valid/ready : serial bit handshake
//   ser_sof/ser_eof     : first / last beat of a frame
module ham_15_11_encoder_ser
  import ham_15_11_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d_in,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic              err_inj_en,
  input  logic [3:0]        err_inj_pos,
  output logic [CW_W-1:0]   cw_out,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_sof,
  output logic              ser_eof
);

  localparam logic [3:0] LAST = 4'(LAST_BIT);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [CW_W-1:0] cw_q, cw_d;
  logic [CW_W-1:0] cw_enc, cw_inj;
  logic [3:0]      ser_idx;
  logic            last_beat, accept;

  ham_15_11_encoder u_enc (
    .data (d_in),
    .cw   (cw_enc)
  );

  always_comb begin
    cw_inj = cw_enc;
    if (err_inj_en && (err_inj_pos != 4'd15))
      cw_inj[err_inj_pos] = ~cw_enc[err_inj_pos];
  end

  // Last beat being taken frees the block in the same cycle: zero-bubble frames
  assign last_beat = (state_q == SHIFT) && (cnt_q == LAST) && ser_ready;
  assign d_ready   = (state_q == IDLE) || last_beat;
  assign accept    = d_valid && d_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cw_d    = cw_q;
    if (accept) begin
      cw_d    = cw_inj;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (last_beat) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if ((state_q == SHIFT) && ser_ready) begin
      cnt_d   = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cw_q    <= cw_d;
    end
  end

  // Outputs come straight from flops, so they hold while ser_ready is low
  assign ser_idx   = LSB_FIRST ? cnt_q : (LAST - cnt_q);
  assign cw_out    = cw_q;
  assign ser_valid = (state_q == SHIFT);
  assign ser_out   = ser_valid & cw_q[ser_idx];
  assign ser_sof   = ser_valid && (cnt_q == 4'd0);
  assign ser_eof   = ser_valid && (cnt_q == LAST);

endmodule

// File: tb/tb_ham_15_11_encoder_ser.sv
module tb_ham_15_11_encoder_ser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] d_in;
  logic        d_valid, err_inj_en, ser_ready;
  logic [3:0]  err_inj_pos;
  logic        d_ready, ser_out, ser_valid, ser_sof, ser_eof;
  logic [14:0] cw_out;
  logic        d_ready2, ser_out2, ser_valid2, ser_sof2, ser_eof2;
  logic [14:0] cw_out2;

  int passed = 0;
  int total  = 0;
  int acc_cnt = 0;
  bit prev_acc = 0;

  typedef struct packed {
    logic        b;
    logic        sof;
    logic        eof;
    logic [14:0] cw;
  } beat_t;

  beat_t q[$];
  beat_t q2[$];

  always #5 clk = ~clk;

  ham_15_11_encoder_ser #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid), .d_ready(d_ready),
    .err_inj_en(err_inj_en), .err_inj_pos(err_inj_pos), .cw_out(cw_out),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_sof(ser_sof), .ser_eof(ser_eof)
  );

  ham_15_11_encoder_ser #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid), .d_ready(d_ready2),
    .err_inj_en(err_inj_en), .err_inj_pos(err_inj_pos), .cw_out(cw_out2),
    .ser_out(ser_out2), .ser_valid(ser_valid2), .ser_ready(ser_ready),
    .ser_sof(ser_sof2), .ser_eof(ser_eof2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference encoder written straight from the parity equations
  function automatic logic [14:0] model_enc(input logic [10:0] d, input logic en,
                                            input logic [3:0] pos);
    logic [14:0] c;
    c = '0;
    c[2] = d[0];  c[4] = d[1];  c[5] = d[2];  c[6] = d[3];
    c[8] = d[4];  c[9] = d[5];  c[10] = d[6]; c[11] = d[7];
    c[12] = d[8]; c[13] = d[9]; c[14] = d[10];
    c[0] = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14];
    c[1] = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
    c[3] = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
    c[7] = c[8] ^ c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
    if (en && pos != 4'd15) c[pos] = ~c[pos];
    return c;
  endfunction

  // Syndrome decoder: XOR of the positions of all set bits names the bad bit
  function automatic logic [10:0] model_dec(input logic [14:0] cw);
    logic [14:0] c;
    logic [3:0]  syn;
    c = cw;
    syn = '0;
    for (int i = 0; i < 15; i++) if (c[i]) syn = syn ^ 4'(i + 1);
    if (syn != 4'd0) c[syn - 4'd1] = ~c[syn - 4'd1];
    return {c[14], c[13], c[12], c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
  endfunction

  task automatic push_frame(input logic [14:0] cw);
    for (int k = 0; k < 15; k++) begin
      q.push_back('{cw[k], k == 0, k == 14, cw});
      q2.push_back('{cw[14 - k], k == 0, k == 14, cw});
    end
  endtask

  // Present a word, wait for acceptance, then queue its expected beats
  task automatic send(input logic [10:0] d, input logic en, input logic [3:0] pos);
    int n;
    n = 0;
    d_in = d; d_valid = 1'b1; err_inj_en = en; err_inj_pos = pos;
    @(negedge clk);
    while (!d_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!d_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (n < 200) push_frame(model_enc(d, en, pos));
    d_valid = 1'b0; err_inj_en = 1'b0; err_inj_pos = 4'd15;
  endtask

  task automatic drain(input bit toggle);
    int n;
    n = 0;
    while (q.size() > 0 && n < 500) begin
      @(posedge clk);
      #1;
      if (toggle) ser_ready = ~ser_ready;
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    ser_ready = 1'b1;
  endtask

  // Scoreboard: every valid beat is compared against the head of the queue;
  // while stalled the head is not popped, so outputs must hold.
  always @(negedge clk) begin
    beat_t h, h2;
    if (rst_n) begin
      if (prev_acc && q.size() > 0) chk("no_bubble", 32'(ser_valid), 32'd1);
      prev_acc = 0;
      if (ser_valid) begin
        if (q.size() == 0 || q2.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          h = q[0];
          h2 = q2[0];
          chk("ser_out", 32'(ser_out), 32'(h.b));
          chk("ser_sof", 32'(ser_sof), 32'(h.sof));
          chk("ser_eof", 32'(ser_eof), 32'(h.eof));
          chk("cw_out", 32'(cw_out), 32'(h.cw));
          chk("d_ready_shift", 32'(d_ready), 32'(h.eof & ser_ready));
          chk("msb_valid", 32'(ser_valid2), 32'd1);
          chk("msb_ser_out", 32'(ser_out2), 32'(h2.b));
          chk("msb_sof", 32'(ser_sof2), 32'(h2.sof));
          chk("msb_eof", 32'(ser_eof2), 32'(h2.eof));
          if (ser_ready) begin
            void'(q.pop_front());
            void'(q2.pop_front());
            acc_cnt++;
            prev_acc = 1;
          end
        end
      end
    end
  end

  initial begin
    int base, n;
    rst_n = 1'b0; d_in = '0; d_valid = 1'b0; err_inj_en = 1'b0;
    err_inj_pos = 4'd15; ser_ready = 1'b1;
    #2;
    chk("rst_valid", 32'(ser_valid), 32'd0);
    chk("rst_ready", 32'(d_ready), 32'd1);
    chk("rst_cw", 32'(cw_out), 32'd0);
    chk("rst_sof_eof_out", 32'({ser_sof, ser_eof, ser_out}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic encodings
    send(11'h001, 1'b0, 4'd15);
    chk("cw_001", 32'(cw_out), 32'h0007);
    drain(1'b0);
    send(11'h7FF, 1'b0, 4'd15);
    chk("cw_7ff", 32'(cw_out), 32'h7FFF);
    drain(1'b0);
    send(11'h000, 1'b0, 4'd15);
    chk("cw_000", 32'(cw_out), 32'h0000);
    drain(1'b0);

    // Back-to-back frames, no bubble
    base = acc_cnt;
    send(11'h001, 1'b0, 4'd15);
    send(11'h7FF, 1'b0, 4'd15);
    drain(1'b0);
    chk("b2b_beats", 32'(acc_cnt - base), 32'd30);

    // Backpressure toggling every cycle
    ser_ready = 1'b0;
    base = acc_cnt;
    send(11'h001, 1'b0, 4'd15);
    drain(1'b1);
    chk("stall_beats", 32'(acc_cnt - base), 32'd15);

    // Error injection
    send(11'h001, 1'b1, 4'd2);
    chk("cw_inj2", 32'(cw_out), 32'h0003);
    chk("dec_inj2", 32'(model_dec(cw_out)), 32'h001);
    drain(1'b0);
    send(11'h001, 1'b1, 4'd15);
    chk("cw_inj15", 32'(cw_out), 32'h0007);
    drain(1'b0);

    // Reset mid-frame at beat 7
    base = acc_cnt;
    send(11'h5A5, 1'b0, 4'd15);
    n = 0;
    while (acc_cnt < base + 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (acc_cnt < base + 7) chk("beat7_timeout", 32'(acc_cnt - base), 32'd7);
    #2 rst_n = 1'b0;
    q.delete();
    q2.delete();
    #1;
    chk("mid_rst_valid", 32'(ser_valid), 32'd0);
    chk("mid_rst_ready", 32'(d_ready), 32'd1);
    chk("mid_rst_cw", 32'(cw_out), 32'd0);
    chk("mid_rst_marks", 32'({ser_sof, ser_eof, ser_out}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(11'h001, 1'b0, 4'd15);
    chk("post_rst_sof", 32'(ser_sof), 32'd1);
    drain(1'b0);

    // Random words, random injection, random backpressure
    for (int r = 0; r < 6; r++) begin
      ser_ready = 1'($urandom_range(0, 1));
      send(11'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      drain(1'b1);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
